// File: rtl/aes_gcm_pkg.sv
// Shared phase/state types and the GCM counter-increment helper for the
// AES-GCM issue front-end.
package aes_gcm_pkg;

    localparam int unsigned BLK_W = 128;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_INIT = 3'd1,
        PH_AAD  = 3'd2,
        PH_PT   = 3'd3,
        PH_LEN  = 3'd4
    } phase_e;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StAad,
        StPt,
        StLen
    } state_e;

    // GCM inc32: only the low word counts, wrapping; the IV part is untouched.
    function automatic logic [BLK_W-1:0] fn_inc32(input logic [BLK_W-1:0] i_cb);
        return {i_cb[BLK_W-1:32], i_cb[31:0] + 32'd1};
    endfunction

endpackage

// File: rtl/aes_gcm_credit_cnt.sv
// Up/down credit counter guarding the downstream result FIFO; starts full and
// saturates at both ends.
module aes_gcm_credit_cnt #(
    parameter int unsigned CREDITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_take,
    input  logic i_return,
    output logic o_has_credit
);

    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(CREDITS);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_take && !i_return && (r_cnt != '0)) begin
            w_cnt_d = r_cnt - CW'(1);
        end else if (i_return && !i_take && (r_cnt != MAX_CNT)) begin
            w_cnt_d = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= MAX_CNT;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_has_credit = (r_cnt != '0);

    // A return with nothing outstanding means the downstream lost count.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(i_return && !i_take && (r_cnt == MAX_CNT)));
    assert property (@(posedge clk) disable iff (!rst_n)
        !(i_take && (r_cnt == '0)));

endmodule

// File: rtl/aes_gcm_issue_ctrl.sv
// Issue scheduler feeding stage 1 of the AES-GCM pipeline: one instance at a
// time, INIT / AAD / PT / LEN beats, credit-limited, all beat fields registered.
module aes_gcm_issue_ctrl
    import aes_gcm_pkg::*;
#(
    parameter int unsigned CREDITS = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [95:0]        i_iv,
    input  logic [CNT_W-1:0]   i_aad_blocks,
    input  logic [CNT_W-1:0]   i_pt_blocks,
    input  logic [63:0]        i_aad_bits,
    input  logic [63:0]        i_pt_bits,
    input  logic [BLK_W-1:0]   i_aad_data,
    input  logic               i_aad_valid,
    output logic               o_aad_ready,
    input  logic [BLK_W-1:0]   i_pt_data,
    input  logic               i_pt_valid,
    output logic               o_pt_ready,
    input  logic               i_credit_return,
    output logic               o_valid,
    output phase_e             o_phase,
    output logic [BLK_W-1:0]   o_plain_text,
    output logic [BLK_W-1:0]   o_aad,
    output logic [BLK_W-1:0]   o_encrypted_cb,
    output logic [BLK_W-1:0]   o_encrypted_j0,
    output logic [BLK_W-1:0]   o_h,
    output logic [BLK_W-1:0]   o_instance_size,
    output logic               o_new_instance,
    output logic               o_busy,
    output logic               o_done
);

    state_e r_state, w_state_d;

    logic [BLK_W-1:0] r_j0, r_cb, r_size;
    logic [CNT_W-1:0] r_aad_left, r_pt_left;
    logic             r_valid, r_new, r_done;
    phase_e           r_phase;
    logic [BLK_W-1:0] r_aad_out, r_pt_out, r_cb_out;

    logic             w_has_credit, w_issue, w_new, w_latch;
    logic             w_aad_fire, w_pt_fire;
    phase_e           w_phase;
    logic [BLK_W-1:0] w_aad_out, w_pt_out, w_cb_d;
    logic [CNT_W-1:0] w_aad_left_d, w_pt_left_d;

    aes_gcm_credit_cnt #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_take       (w_issue),
        .i_return     (i_credit_return),
        .o_has_credit (w_has_credit)
    );

    assign o_aad_ready = (r_state == StAad) && w_has_credit;
    assign o_pt_ready  = (r_state == StPt) && w_has_credit;
    assign w_aad_fire  = i_aad_valid && o_aad_ready;
    assign w_pt_fire   = i_pt_valid && o_pt_ready;

    always_comb begin
        w_state_d    = r_state;
        w_issue      = 1'b0;
        w_new        = 1'b0;
        w_latch      = 1'b0;
        w_phase      = PH_IDLE;
        w_aad_out    = '0;
        w_pt_out     = '0;
        w_cb_d       = r_cb;
        w_aad_left_d = r_aad_left;
        w_pt_left_d  = r_pt_left;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_latch   = 1'b1;
                    w_state_d = StInit;
                end
            end
            StInit: begin
                if (w_has_credit) begin
                    w_issue = 1'b1;
                    w_new   = 1'b1;
                    w_phase = PH_INIT;
                    if (r_aad_left != '0)     w_state_d = StAad;
                    else if (r_pt_left != '0) w_state_d = StPt;
                    else                      w_state_d = StLen;
                end
            end
            StAad: begin
                if (w_aad_fire) begin
                    w_issue      = 1'b1;
                    w_phase      = PH_AAD;
                    w_aad_out    = i_aad_data;
                    w_aad_left_d = r_aad_left - CNT_W'(1);
                    if (r_aad_left == CNT_W'(1)) begin
                        w_state_d = (r_pt_left != '0) ? StPt : StLen;
                    end
                end
            end
            StPt: begin
                if (w_pt_fire) begin
                    w_issue     = 1'b1;
                    w_phase     = PH_PT;
                    w_pt_out    = i_pt_data;
                    w_cb_d      = fn_inc32(r_cb);
                    w_pt_left_d = r_pt_left - CNT_W'(1);
                    if (r_pt_left == CNT_W'(1)) w_state_d = StLen;
                end
            end
            StLen: begin
                if (w_has_credit) begin
                    w_issue   = 1'b1;
                    w_phase   = PH_LEN;
                    w_aad_out = r_size;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_j0       <= '0;
            r_cb       <= '0;
            r_size     <= '0;
            r_aad_left <= '0;
            r_pt_left  <= '0;
            r_valid    <= 1'b0;
            r_new      <= 1'b0;
            r_done     <= 1'b0;
            r_phase    <= PH_IDLE;
            r_aad_out  <= '0;
            r_pt_out   <= '0;
            r_cb_out   <= '0;
        end else begin
            if (w_latch) begin
                r_j0       <= {i_iv, 32'h1};
                r_cb       <= {i_iv, 32'h1};
                r_size     <= {i_aad_bits, i_pt_bits};
                r_aad_left <= i_aad_blocks;
                r_pt_left  <= i_pt_blocks;
            end else begin
                r_cb       <= w_cb_d;
                r_aad_left <= w_aad_left_d;
                r_pt_left  <= w_pt_left_d;
            end
            r_valid <= w_issue;
            r_new   <= w_issue && w_new;
            // Bubbles keep the last beat's fields so stage 1 sees stable data.
            if (w_issue) begin
                r_phase   <= w_phase;
                r_aad_out <= w_aad_out;
                r_pt_out  <= w_pt_out;
                r_cb_out  <= w_cb_d;
            end
            r_done <= r_valid && (r_phase == PH_LEN);
        end
    end

    assign o_valid         = r_valid;
    assign o_phase         = r_phase;
    assign o_plain_text    = r_pt_out;
    assign o_aad           = r_aad_out;
    assign o_encrypted_cb  = r_cb_out;
    assign o_encrypted_j0  = r_j0;
    assign o_h             = '0;
    assign o_instance_size = r_size;
    assign o_new_instance  = r_new;
    assign o_busy          = (r_state != StIdle);
    assign o_done          = r_done;

endmodule

// File: tb/tb_aes_gcm_issue_ctrl.sv
// Bench for aes_gcm_issue_ctrl: an instance-level beat-list model scored every
// cycle, plus literal checks on counters, LEN block and done timing.
module tb_aes_gcm_issue_ctrl;
    import aes_gcm_pkg::*;

    localparam int unsigned CREDITS = 2;
    localparam int unsigned CNT_W   = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_start = 1'b0;
    logic [95:0] i_iv = '0;
    logic [CNT_W-1:0] i_aad_blocks = '0, i_pt_blocks = '0;
    logic [63:0] i_aad_bits = '0, i_pt_bits = '0;
    logic [127:0] i_aad_data = '0, i_pt_data = '0;
    logic i_aad_valid = 1'b0, i_pt_valid = 1'b0, i_credit_return = 1'b0;
    logic o_aad_ready, o_pt_ready, o_valid, o_new_instance, o_busy, o_done;
    phase_e o_phase;
    logic [127:0] o_plain_text, o_aad, o_encrypted_cb, o_encrypted_j0, o_h, o_instance_size;

    aes_gcm_issue_ctrl #(
        .CREDITS (CREDITS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_iv            (i_iv),
        .i_aad_blocks    (i_aad_blocks),
        .i_pt_blocks     (i_pt_blocks),
        .i_aad_bits      (i_aad_bits),
        .i_pt_bits       (i_pt_bits),
        .i_aad_data      (i_aad_data),
        .i_aad_valid     (i_aad_valid),
        .o_aad_ready     (o_aad_ready),
        .i_pt_data       (i_pt_data),
        .i_pt_valid      (i_pt_valid),
        .o_pt_ready      (o_pt_ready),
        .i_credit_return (i_credit_return),
        .o_valid         (o_valid),
        .o_phase         (o_phase),
        .o_plain_text    (o_plain_text),
        .o_aad           (o_aad),
        .o_encrypted_cb  (o_encrypted_cb),
        .o_encrypted_j0  (o_encrypted_j0),
        .o_h             (o_h),
        .o_instance_size (o_instance_size),
        .o_new_instance  (o_new_instance),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        phase_e       ph;
        logic [127:0] cb;
        logic [127:0] aad;
        logic [127:0] pt;
        logic         nw;
    } beat_t;

    beat_t        exp_q[$];
    logic [127:0] aad_arr[$];
    logic [127:0] pt_arr[$];
    logic [127:0] cur_j0 = '0, cur_size = '0;
    logic [127:0] last_pt_cb = '0, last_len = '0;
    int  aad_idx = 0, pt_idx = 0;
    bit  aad_fire = 0, pt_fire = 0, prev_len = 0;
    int  n_chk = 0, n_fail = 0;
    int  cyc = 0, beats = 0, done_cnt = 0, owed = 0;
    int  gap_pct = 0, ret_budget = 1000000;
    int  init_cyc = 0, done_cyc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Expected beat list for one instance, from the GCM rules directly.
    task automatic plan(input logic [95:0] iv, input int na, input int np,
                        input logic [63:0] ab, input logic [63:0] pb);
        beat_t b;
        logic [31:0] lo;
        cur_j0   = {iv, 32'h1};
        cur_size = {ab, pb};
        aad_arr.delete();
        pt_arr.delete();
        for (int i = 0; i < na; i++) aad_arr.push_back({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < np; i++) pt_arr.push_back({$urandom, $urandom, $urandom, $urandom});
        b.ph = PH_INIT; b.cb = cur_j0; b.aad = '0; b.pt = '0; b.nw = 1'b1;
        exp_q.push_back(b);
        for (int i = 0; i < na; i++) begin
            b.ph = PH_AAD; b.cb = cur_j0; b.aad = aad_arr[i]; b.pt = '0; b.nw = 1'b0;
            exp_q.push_back(b);
        end
        for (int k = 1; k <= np; k++) begin
            lo = 32'h1 + 32'(k);
            b.ph = PH_PT; b.cb = {iv, lo}; b.aad = '0; b.pt = pt_arr[k-1]; b.nw = 1'b0;
            exp_q.push_back(b);
        end
        lo = 32'h1 + 32'(np);
        b.ph = PH_LEN; b.cb = {iv, lo}; b.aad = {ab, pb}; b.pt = '0; b.nw = 1'b0;
        exp_q.push_back(b);
        aad_idx = 0;
        pt_idx  = 0;
    endtask

    task automatic start(input logic [95:0] iv, input int na, input int np,
                         input logic [63:0] ab, input logic [63:0] pb);
        plan(iv, na, np, ab, pb);
        @(negedge clk);
        i_iv = iv; i_aad_blocks = 32'(na); i_pt_blocks = 32'(np);
        i_aad_bits = ab; i_pt_bits = pb;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        #1;
        while ((exp_q.size() != 0 || o_busy || owed != 0) && n < max_cyc) begin
            @(negedge clk); #1;
            n++;
        end
        chk("idle_timeout", 128'(n < max_cyc), 128'd1);
        repeat (3) @(negedge clk);
    endtask

    always @(posedge clk) cyc++;

    // Monitor, downstream credit return and both block sources.
    always @(negedge clk) begin
        beat_t e;
        bit ok;
        if (!rst_n) begin
            owed = 0; i_credit_return = 1'b0;
            i_aad_valid = 1'b0; i_pt_valid = 1'b0;
            aad_fire = 0; pt_fire = 0; prev_len = 0;
        end else begin
            if (aad_fire) aad_idx++;
            if (pt_fire) pt_idx++;
            chk("done_timing", 128'(o_done), 128'(prev_len));
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            prev_len = o_valid && (o_phase == PH_LEN);
            if (o_valid) begin
                beats++;
                owed++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 128'(o_phase), 128'(PH_IDLE));
                end else begin
                    e = exp_q.pop_front();
                    chk("phase", 128'(o_phase), 128'(e.ph));
                    chk("cb", o_encrypted_cb, e.cb);
                    chk("aad", o_aad, e.aad);
                    chk("pt", o_plain_text, e.pt);
                    chk("new_inst", 128'(o_new_instance), 128'(e.nw));
                    chk("j0", o_encrypted_j0, cur_j0);
                    chk("size", o_instance_size, cur_size);
                    chk("h", o_h, 128'd0);
                    if (e.ph == PH_PT) last_pt_cb = o_encrypted_cb;
                    if (e.ph == PH_LEN) last_len = o_aad;
                    if (e.ph == PH_INIT) init_cyc = cyc;
                end
            end else begin
                chk("new_inst_bubble", 128'(o_new_instance), 128'd0);
            end
            if (o_aad_ready) begin
                ok = (exp_q.size() > 0) ? (exp_q[0].ph == PH_AAD) : 1'b0;
                chk("aad_ready_phase", 128'(ok), 128'd1);
            end
            if (o_pt_ready) begin
                ok = (exp_q.size() > 0) ? (exp_q[0].ph == PH_PT) : 1'b0;
                chk("pt_ready_phase", 128'(ok), 128'd1);
            end
            if (owed > 0 && ret_budget > 0) begin
                i_credit_return = 1'b1; owed--; ret_budget--;
            end else begin
                i_credit_return = 1'b0;
            end
            i_aad_valid = (aad_idx < aad_arr.size()) && ($urandom_range(99, 0) >= 32'(gap_pct));
            i_aad_data  = (aad_idx < aad_arr.size()) ? aad_arr[aad_idx] : '0;
            i_pt_valid  = (pt_idx < pt_arr.size()) && ($urandom_range(99, 0) >= 32'(gap_pct));
            i_pt_data   = (pt_idx < pt_arr.size()) ? pt_arr[pt_idx] : '0;
            aad_fire = i_aad_valid && o_aad_ready;
            pt_fire  = i_pt_valid && o_pt_ready;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 128'(o_valid), 128'd0);
        chk({tag, "_busy"}, 128'(o_busy), 128'd0);
        chk({tag, "_done"}, 128'(o_done), 128'd0);
        chk({tag, "_phase"}, 128'(o_phase), 128'd0);
        chk({tag, "_cb"}, o_encrypted_cb, 128'd0);
        chk({tag, "_j0"}, o_encrypted_j0, 128'd0);
        chk({tag, "_size"}, o_instance_size, 128'd0);
        chk({tag, "_aad"}, o_aad, 128'd0);
        chk({tag, "_pt"}, o_plain_text, 128'd0);
        chk({tag, "_ready"}, 128'({o_aad_ready, o_pt_ready, o_new_instance}), 128'd0);
    endtask

    initial begin
        int b0, d0, n;
        logic [127:0] wrap_in;

        #2;
        chk_all_zero("reset");
        wrap_in = 128'hCAFEBABEFACEDBADDECAF888_FFFFFFFE;
        chk("inc32_fe", fn_inc32(wrap_in), 128'hCAFEBABEFACEDBADDECAF888_FFFFFFFF);
        wrap_in = 128'hCAFEBABEFACEDBADDECAF888_FFFFFFFF;
        chk("inc32_wrap", fn_inc32(wrap_in), 128'hCAFEBABEFACEDBADDECAF888_00000000);
        wrap_in = 128'hCAFEBABEFACEDBADDECAF888_00000000;
        chk("inc32_zero", fn_inc32(wrap_in), 128'hCAFEBABEFACEDBADDECAF888_00000001);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Nominal instance: 2 AAD, 4 PT.
        b0 = beats; d0 = done_cnt;
        start(96'hCAFEBABEFACEDBADDECAF888, 2, 4, 64'd200, 64'd480);
        wait_idle(300);
        chk("t1_beats", 128'(beats - b0), 128'd8);
        chk("t1_last_cb", last_pt_cb, 128'hCAFEBABEFACEDBADDECAF888_00000005);
        chk("t1_len", last_len, {64'd200, 64'd480});
        chk("t1_done", 128'(done_cnt - d0), 128'd1);

        // Empty instance: INIT then zero LEN block, done two cycles after INIT.
        b0 = beats; d0 = done_cnt;
        start(96'h0123456789ABCDEF01234567, 0, 0, 64'd0, 64'd0);
        wait_idle(100);
        chk("t2_beats", 128'(beats - b0), 128'd2);
        chk("t2_len", last_len, 128'd0);
        chk("t2_done_lat", 128'(done_cyc - init_cyc), 128'd2);
        chk("t2_done", 128'(done_cnt - d0), 128'd1);

        // Credit starvation: no returns, then exactly one.
        ret_budget = 0;
        b0 = beats;
        start(96'h111122223333444455556666, 0, 5, 64'd0, 64'd640);
        repeat (15) @(negedge clk);
        #1;
        chk("t3_stall_beats", 128'(beats - b0), 128'd2);
        chk("t3_stall_ready", 128'(o_pt_ready), 128'd0);
        @(posedge clk);
        ret_budget = 1;
        repeat (15) @(negedge clk);
        #1;
        chk("t3_one_more", 128'(beats - b0), 128'd3);
        chk("t3_ready_low", 128'(o_pt_ready), 128'd0);
        @(posedge clk);
        ret_budget = 1000000;
        wait_idle(300);
        chk("t3_beats", 128'(beats - b0), 128'd7);

        // Random source gaps plus a stray start while busy.
        gap_pct = 40;
        b0 = beats;
        start(96'hA5A5A5A55A5A5A5AFFFF0000, 3, 5, 64'd384, 64'd600);
        repeat (3) @(negedge clk);
        chk("t4_busy", 128'(o_busy), 128'd1);
        i_iv = 96'h0; i_aad_blocks = 32'd7; i_aad_bits = 64'hDEAD;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_idle(600);
        chk("t4_beats", 128'(beats - b0), 128'd10);

        // Reset in the middle of the PT phase.
        gap_pct = 0;
        start(96'h00000000FEEDFACE12345678, 1, 6, 64'd100, 64'd700);
        n = 0;
        while (pt_idx < 2 && n < 200) begin @(negedge clk); n++; end
        chk("t5_reach_pt", 128'(n < 200), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_q.delete(); aad_arr.delete(); pt_arr.delete();
        aad_idx = 0; pt_idx = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        gap_pct = 30;
        b0 = beats; d0 = done_cnt;
        start(96'h9999888877776666AAAA5555, 1, 2, 64'd120, 64'd256);
        wait_idle(300);
        chk("t6_beats", 128'(beats - b0), 128'd5);
        chk("t6_len", last_len, {64'd120, 64'd256});
        chk("t6_done", 128'(done_cnt - d0), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
